fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the single-issue RV32 core, directly upstream of `control_unit`. Owns the program counter and drives a synchronous-read instruction memory. Presents one instruction per cycle, with its PC, to decode/control. Honours the fetch stall from control and redirects from branch/jump resolution in EX, squashing the wrong-path instruction.

## Interface
Parameters:
- `IMEM_DEPTH`, default 4096: instruction memory depth in 32-bit words, power of two; `AW = $clog2(IMEM_DEPTH)`.
- `RESET_PC`, default 32'h0000_0000: first fetch address; must be 4-byte aligned.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_FETCH`  in  1  hold the current instruction and PC (from `control_unit`).
- `redirect_EX`  in  1  taken branch/jump resolved in EX this cycle.
- `redirect_pc_EX`  in  32  redirect target byte address.
- `imem_addr`  out  AW  word address to IMEM; combinational.
- `imem_rdata`  in  32  IMEM data; word at the address presented in cycle n appears in cycle n+1.
- `instr_EX`  out  32  instruction to `control_unit`.
- `pc_EX`  out  32  byte PC of `instr_EX`.
- `valid_EX`  out  1  `instr_EX` is a real, non-squashed instruction.
- `misalign_err`  out  1  sticky: a redirect target had nonzero bits [1:0].

## Operation
- State: `pc_f` (next address to issue), `pc_d` (PC of the word currently on `imem_rdata`), `valid_d`, and sticky `misalign_err`.
- Target alignment: `tgt = {redirect_pc_EX[31:2], 2'b00}`.
- `imem_addr` selection, in priority order:
  - `tgt[AW+1:2]` if `redirect_EX`.
  - Else `pc_d[AW+1:2]` if `stall_FETCH`. The same word is re-read, so `imem_rdata` stays stable.
  - Else `pc_f[AW+1:2]`.
- Next-state priority: rst > redirect > stall > advance.
  - rst: `pc_f<=RESET_PC`, `pc_d<=RESET_PC`, `valid_d<=0`, `misalign_err<=0`.
  - redirect: `pc_d<=tgt`, `pc_f<=tgt+4`, `valid_d<=1`. If `redirect_pc_EX[1:0]!=0`, `misalign_err<=1`.
  - stall: all state holds.
  - advance: `pc_d<=pc_f`, `pc_f<=pc_f+4`, `valid_d<=1`.
- Outputs:
  - `pc_EX=pc_d`.
  - `valid_EX = valid_d & ~redirect_EX`.
  - `instr_EX = valid_EX ? imem_rdata : NOP_INSTR` (32'h0000_0013).
- The redirect cycle squashes the instruction currently presented. The target instruction is presented the following cycle, giving exactly one bubble.
- `redirect_EX` together with `stall_FETCH`: redirect wins; the stall is ignored that cycle.
- PC arithmetic is modulo 2^32. `imem_addr` takes PC bits [AW+1:2], so the fetch address wraps at `IMEM_DEPTH` words.

## Timing
- Reset values: `pc_EX=RESET_PC`, `valid_EX=0`, `instr_EX=NOP_INSTR`, `misalign_err=0`, `imem_addr=RESET_PC[AW+1:2]`.
- Startup: first edge with `rst=0` is E1. In the cycle after E1, `instr_EX` = IMEM[`RESET_PC`] with `valid_EX=1`.
- Steady state: one instruction per cycle. Latency from `imem_addr` issue to `instr_EX` is 1 cycle.
- Stall release: the next sequential instruction appears one cycle after `stall_FETCH` falls. No instruction is lost or duplicated.
- Reset asserted mid-stall or mid-redirect: reset values appear after the next edge; the pending redirect is discarded.
- Redirect-to-target latency: 1 cycle.

## Configuration
- `FETCH_PERF_EN` defined: adds three 32-bit output ports, each reset to 0 and wrapping modulo 2^32.
  - `perf_instr_cnt`: increments each cycle with `valid_EX & ~stall_FETCH`.
  - `perf_stall_cnt`: increments each cycle with `stall_FETCH & ~redirect_EX`.
  - `perf_flush_cnt`: increments each cycle with `redirect_EX`.
- `FETCH_PERF_EN` undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `cpu_pkg`:
  - `XLEN=32`.
  - `NOP_INSTR=32'h0000_0013`.
  - `DEFAULT_RESET_PC`, which `RESET_PC` defaults from.
- Sub-module `fetch_perf_counters`: holds the three counters. Instantiated only under `FETCH_PERF_EN`.
- PC and squash logic stay in `fetch_stage`.

## Test plan
- Reset/startup: `RESET_PC=0`, IMEM[0..3] = 0x11,0x22,0x33,0x44.
  - Release `rst`.
  - Required: NOP/valid 0 for one cycle, then `instr_EX` 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `pc_EX` 0, 4, 8, 12.
- Stall: assert `stall_FETCH` 3 cycles while `pc_EX=8`.
  - Required: `instr_EX=0x33` and `pc_EX=8` held for all 3 cycles.
  - Then 0x44 at `pc_EX=12`; no skip, no duplicate.
- Redirect: `redirect_EX=1`, `redirect_pc_EX=0x40` while `pc_EX=4`.
  - Required: that cycle `valid_EX=0` and `instr_EX=0x13`.
  - Next cycle `pc_EX=0x40` with IMEM[16]; then 0x44.
- Redirect + stall in the same cycle, target 0x80: redirect wins.
  - Required: next cycle `pc_EX=0x80`, `valid_EX=1`.
- Misaligned target 0x42.
  - Required: fetch from 0x40, `misalign_err=1`, held until `rst`.
- Wrap with `IMEM_DEPTH=16`: redirect to 0x3C.
  - Required: `pc_EX` 0x3C, then 0x40 with `imem_addr` 0.
  - With `FETCH_PERF_EN`: counters match the cycle counts above.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core constants: datapath width, canonical NOP and default boot address.
package cpu_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory port: word address out, synchronous-read data back one cycle later.
interface fetch_stage_if
  import cpu_pkg::*;
#(
  parameter int unsigned AW = 12
);

  logic [AW-1:0]   imem_addr;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);

endinterface

// File: rtl/fetch_perf_counters.sv
// Fetch performance counters: delivered instructions, stall cycles and flush cycles.
module fetch_perf_counters
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_EX,
  input  logic            stall_FETCH,
  input  logic            redirect_EX,
  output logic [XLEN-1:0] perf_instr_cnt,
  output logic [XLEN-1:0] perf_stall_cnt,
  output logic [XLEN-1:0] perf_flush_cnt
);

  logic [XLEN-1:0] instr_cnt_q, instr_cnt_d;
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (valid_EX && !stall_FETCH)    instr_cnt_d = instr_cnt_q + XLEN'(1);
    if (stall_FETCH && !redirect_EX) stall_cnt_d = stall_cnt_q + XLEN'(1);
    if (redirect_EX)                 flush_cnt_d = flush_cnt_q + XLEN'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_instr_cnt = instr_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: owns the PC, drives sync-read IMEM, handles stall and EX redirect.
// Define FETCH_PERF_EN to add the perf_* counter outputs.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     IMEM_DEPTH = 4096,
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_FETCH,
  input  logic            redirect_EX,
  input  logic [XLEN-1:0] redirect_pc_EX,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] instr_EX,
  output logic [XLEN-1:0] pc_EX,
  output logic            valid_EX,
  output logic            misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] perf_instr_cnt,
  output logic [XLEN-1:0] perf_stall_cnt,
  output logic [XLEN-1:0] perf_flush_cnt
`endif
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pc_d_q, pc_d_d;
  logic            valid_d_q, valid_d_d;
  logic            misalign_err_q, misalign_err_d;
  logic [XLEN-1:0] tgt;
  logic            valid_c;

  assign tgt = {redirect_pc_EX[XLEN-1:2], 2'b00};

  // Next-state: redirect beats stall beats sequential advance
  always_comb begin
    pc_f_d         = pc_f_q;
    pc_d_d         = pc_d_q;
    valid_d_d      = valid_d_q;
    misalign_err_d = misalign_err_q;
    if (redirect_EX) begin
      pc_d_d    = tgt;
      pc_f_d    = tgt + XLEN'(4);
      valid_d_d = 1'b1;
      if (redirect_pc_EX[1:0] != 2'b00) misalign_err_d = 1'b1;
    end else if (!stall_FETCH) begin
      pc_d_d    = pc_f_q;
      pc_f_d    = pc_f_q + XLEN'(4);
      valid_d_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q         <= RESET_PC;
      pc_d_q         <= RESET_PC;
      valid_d_q      <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      pc_f_q         <= pc_f_d;
      pc_d_q         <= pc_d_d;
      valid_d_q      <= valid_d_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  // Stall re-reads the presented word so imem_rdata stays put
  always_comb begin
    imem.imem_addr = pc_f_q[AW+1:2];
    if (redirect_EX)      imem.imem_addr = tgt[AW+1:2];
    else if (stall_FETCH) imem.imem_addr = pc_d_q[AW+1:2];
  end

  // The word on imem_rdata during a redirect is wrong-path and gets squashed
  always_comb begin
    valid_c  = valid_d_q & ~redirect_EX;
    valid_EX = valid_c;
    instr_EX = valid_c ? imem.imem_rdata : NOP_INSTR;
    pc_EX    = pc_d_q;
  end

  assign misalign_err = misalign_err_q;

`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .clk            (clk),
    .rst            (rst),
    .valid_EX       (valid_c),
    .stall_FETCH    (stall_FETCH),
    .redirect_EX    (redirect_EX),
    .perf_instr_cnt (perf_instr_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table on a 4096-word instance, wrap sequence on a 16-word one.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- main instance (IMEM_DEPTH 4096) ----------------
  logic        rst, stall, redir;
  logic [31:0] rpc, instr, pc;
  logic        valid, mis;
  logic [31:0] mem [0:4095];
  fetch_stage_if #(.AW(12)) mif ();

  always @(posedge clk) mif.imem_rdata <= mem[mif.imem_addr];

`ifdef FETCH_PERF_EN
  logic [31:0] m_pi, m_ps, m_pf;
`endif

  fetch_stage #(.IMEM_DEPTH(4096), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .stall_FETCH(stall), .redirect_EX(redir), .redirect_pc_EX(rpc),
    .imem(mif.master), .instr_EX(instr), .pc_EX(pc), .valid_EX(valid), .misalign_err(mis)
`ifdef FETCH_PERF_EN
    , .perf_instr_cnt(m_pi), .perf_stall_cnt(m_ps), .perf_flush_cnt(m_pf)
`endif
  );

  // ---------------- wrap instance (IMEM_DEPTH 16) ----------------
  logic        w_rst, w_stall, w_redir;
  logic [31:0] w_rpc, w_instr, w_pc;
  logic        w_valid, w_mis;
  logic [31:0] wmem [0:15];
  fetch_stage_if #(.AW(4)) wif ();

  always @(posedge clk) wif.imem_rdata <= wmem[wif.imem_addr];

`ifdef FETCH_PERF_EN
  logic [31:0] w_pi, w_ps, w_pf;
`endif

  fetch_stage #(.IMEM_DEPTH(16), .RESET_PC(32'h0)) u_wrap (
    .clk(clk), .rst(w_rst), .stall_FETCH(w_stall), .redirect_EX(w_redir), .redirect_pc_EX(w_rpc),
    .imem(wif.master), .instr_EX(w_instr), .pc_EX(w_pc), .valid_EX(w_valid), .misalign_err(w_mis)
`ifdef FETCH_PERF_EN
    , .perf_instr_cnt(w_pi), .perf_stall_cnt(w_ps), .perf_flush_cnt(w_pf)
`endif
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_mis;
    logic [11:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = '0;
    w_rst = 1'b1; w_stall = 1'b0; w_redir = 1'b0; w_rpc = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    for (int i = 0; i < 16; i++) wmem[i] = 32'hBEEF_0000 | 32'(i);

    // inputs for the cycle | expected outputs observed in that cycle
    vecs.push_back('{1, 0, 0, 32'h0,   0, NOP,          32'h00, 0, 12'd0});  // reset state
    vecs.push_back('{0, 0, 0, 32'h0,   0, NOP,          32'h00, 0, 12'd0});  // bubble before E1
    vecs.push_back('{0, 0, 0, 32'h0,   1, 32'h11,       32'h00, 0, 12'd1});
    vecs.push_back('{0, 0, 0, 32'h0,   1, 32'h22,       32'h04, 0, 12'd2});
    vecs.push_back('{0, 1, 0, 32'h0,   1, 32'h33,       32'h08, 0, 12'd2});  // stall x3
    vecs.push_back('{0, 1, 0, 32'h0,   1, 32'h33,       32'h08, 0, 12'd2});
    vecs.push_back('{0, 1, 0, 32'h0,   1, 32'h33,       32'h08, 0, 12'd2});
    vecs.push_back('{0, 0, 0, 32'h0,   1, 32'h33,       32'h08, 0, 12'd3});  // release
    vecs.push_back('{0, 0, 0, 32'h0,   1, 32'h44,       32'h0C, 0, 12'd4});
    vecs.push_back('{0, 0, 1, 32'h4,   0, NOP,          32'h10, 0, 12'd1});  // redirect to 4
    vecs.push_back('{0, 0, 1, 32'h40,  0, NOP,          32'h04, 0, 12'd16}); // redirect at pc 4
    vecs.push_back('{0, 0, 0, 32'h0,   1, 32'hC0DE_0010, 32'h40, 0, 12'd17});
    vecs.push_back('{0, 1, 1, 32'h80,  0, NOP,          32'h44, 0, 12'd32}); // redirect + stall
    vecs.push_back('{0, 0, 0, 32'h0,   1, 32'hC0DE_0020, 32'h80, 0, 12'd33});
    vecs.push_back('{0, 0, 1, 32'h42,  0, NOP,          32'h84, 0, 12'd16}); // misaligned target
    vecs.push_back('{0, 0, 0, 32'h0,   1, 32'hC0DE_0010, 32'h40, 1, 12'd17});
    vecs.push_back('{1, 1, 0, 32'h0,   1, 32'hC0DE_0011, 32'h44, 1, 12'd17}); // reset mid-stall
    vecs.push_back('{1, 0, 1, 32'h100, 0, NOP,          32'h00, 0, 12'd64}); // reset mid-redirect
    vecs.push_back('{0, 0, 0, 32'h0,   0, NOP,          32'h00, 0, 12'd0});
    vecs.push_back('{0, 0, 0, 32'h0,   1, 32'h11,       32'h00, 0, 12'd1});

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; stall = vecs[i].stall; redir = vecs[i].redir; rpc = vecs[i].rpc;
      #1;
      check($sformatf("row%0d valid", i), 32'(valid), 32'(vecs[i].e_valid));
      check($sformatf("row%0d instr", i), instr, vecs[i].e_instr);
      check($sformatf("row%0d pc", i), pc, vecs[i].e_pc);
      check($sformatf("row%0d misalign", i), 32'(mis), 32'(vecs[i].e_mis));
      check($sformatf("row%0d addr", i), 32'(mif.imem_addr), 32'(vecs[i].e_addr));
    end
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redir = 1'b0;

    // wrap: redirect to last word of a 16-word IMEM, then fall through to word 0
    w_rst = 1'b0;
    #1 check("wrap idle valid", 32'(w_valid), 32'd0);
    @(negedge clk);
    w_redir = 1'b1; w_rpc = 32'h3C;
    #1 check("wrap redir valid", 32'(w_valid), 32'd0);
    check("wrap redir addr", 32'(wif.imem_addr), 32'd15);
    @(negedge clk);
    w_redir = 1'b0;
    #1 check("wrap pc3c pc", w_pc, 32'h3C);
    check("wrap pc3c instr", w_instr, 32'hBEEF_000F);
    check("wrap pc3c addr", 32'(wif.imem_addr), 32'd0);
    @(negedge clk);
    w_stall = 1'b1;
    #1 check("wrap pc40 pc", w_pc, 32'h40);
    check("wrap pc40 instr", w_instr, 32'hBEEF_0000);
    check("wrap pc40 valid", 32'(w_valid), 32'd1);
    check("wrap stall addr", 32'(wif.imem_addr), 32'd0);
    @(negedge clk);
    w_stall = 1'b0;
    #1 check("wrap held pc", w_pc, 32'h40);
    check("wrap held instr", w_instr, 32'hBEEF_0000);
    check("wrap held addr", 32'(wif.imem_addr), 32'd1);
    @(negedge clk);
    #1 check("wrap pc44 pc", w_pc, 32'h44);
    check("wrap pc44 instr", w_instr, 32'hBEEF_0001);
`ifdef FETCH_PERF_EN
    check("perf instr", w_pi, 32'd2);
    check("perf stall", w_ps, 32'd1);
    check("perf flush", w_pf, 32'd1);
    check("perf main reset", m_pi, 32'd0);
`endif
    check("wrap misalign", 32'(w_mis), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
